// File: rtl/ram_xaxd_be_clr_if.sv
// Request/response bundle for ram_xaxd_be_clr: write port, read port and clear control.
interface ram_xaxd_be_clr_if #(
    parameter int CAddrLen = 8,
    parameter int CLaneLen = 8,
    parameter int CLaneCnt = 2
);
    localparam int CDataLen = CLaneLen * CLaneCnt;

    logic [CAddrLen-1:0] AAddrWr;
    logic [CDataLen-1:0] AMosi;
    logic                AWrEn;
    logic [CLaneCnt-1:0] AWrMask;
    logic [CAddrLen-1:0] AAddrRd;
    logic                ARdEn;
    logic [CDataLen-1:0] AMiso;
    logic                AMisoVld;
    logic                AClrReq;
    logic                AClrBusy;

    modport master (
        output AAddrWr, AMosi, AWrEn, AWrMask, AAddrRd, ARdEn, AClrReq,
        input  AMiso, AMisoVld, AClrBusy
    );

    modport slave (
        input  AAddrWr, AMosi, AWrEn, AWrMask, AAddrRd, ARdEn, AClrReq,
        output AMiso, AMisoVld, AClrBusy
    );
endinterface

// File: rtl/ram_xaxd_be_clr.sv
// Single-clock sim RAM with lane-masked writes, optional output register and a sequential clear engine.
// Define RAM_XAXD_BYPASS_EN for write-first forwarding on a same-address read/write; default is read-first.
module ram_xaxd_be_clr_lane #(
    parameter int CLaneLen = 8
) (
    input  logic [CLaneLen-1:0] old_lane,
    input  logic [CLaneLen-1:0] new_lane,
    input  logic                sel,
    output logic [CLaneLen-1:0] lane
);
    assign lane = sel ? new_lane : old_lane;
endmodule

module ram_xaxd_be_clr #(
    parameter int CAddrLen  = 8,
    parameter int CLaneLen  = 8,
    parameter int CLaneCnt  = 2,
    parameter int CRdReg    = 0,
    parameter int CClrOnRst = 1,
    parameter int CClrVal   = 0
) (
    input  logic               AClkH,
    input  logic               AResetH,
    input  logic               AClkHEn,
    ram_xaxd_be_clr_if.slave   bus
);
    localparam int CRamSize = 1 << CAddrLen;

    typedef logic [CLaneCnt-1:0][CLaneLen-1:0] word_t;
    typedef enum logic {ST_IDLE, ST_CLR} clr_st_t;

    localparam logic [CLaneLen-1:0] CLaneFill = CLaneLen'(CClrVal);
    localparam word_t               CFill     = {CLaneCnt{CLaneFill}};

    word_t               mem [CRamSize];
    logic [CAddrLen-1:0] f_addr_wr, f_addr_rd, clr_cnt;
    word_t               f_mosi;
    logic [CLaneCnt-1:0] f_wr_mask;
    logic                f_wr_en, f_rd_en, f_clr_req, f_live;
    clr_st_t             clr_st;
    logic                clr_busy;
    word_t               wr_word, rd_raw, rd_word, rd_live;
    logic                rd_hit;

    // f_live keeps AMiso at zero from reset until the first enabled edge.
    always_ff @(posedge AClkH or posedge AResetH) begin
        if (AResetH) begin
            f_addr_wr <= '0;
            f_mosi    <= '0;
            f_wr_en   <= 1'b0;
            f_wr_mask <= '0;
            f_addr_rd <= '0;
            f_rd_en   <= 1'b0;
            f_clr_req <= 1'b0;
            f_live    <= 1'b0;
        end else if (AClkHEn) begin
            f_addr_wr <= bus.AAddrWr;
            f_mosi    <= bus.AMosi;
            f_wr_en   <= bus.AWrEn;
            f_wr_mask <= bus.AWrMask;
            f_addr_rd <= bus.AAddrRd;
            f_rd_en   <= bus.ARdEn;
            f_clr_req <= bus.AClrReq;
            f_live    <= 1'b1;
        end
    end

    always_ff @(posedge AClkH or posedge AResetH) begin
        if (AResetH) begin
            clr_st   <= (CClrOnRst != 0) ? ST_CLR : ST_IDLE;
            clr_busy <= (CClrOnRst != 0);
            clr_cnt  <= '0;
        end else if (AClkHEn) begin
            case (clr_st)
                ST_IDLE: begin
                    if (f_clr_req) begin
                        clr_st   <= ST_CLR;
                        clr_busy <= 1'b1;
                        clr_cnt  <= '0;
                    end
                end
                ST_CLR: begin
                    if (clr_cnt == '1) begin
                        clr_st   <= ST_IDLE;
                        clr_busy <= 1'b0;
                        clr_cnt  <= '0;
                    end else begin
                        clr_cnt <= clr_cnt + 1'b1;
                    end
                end
                default: begin
                    clr_st   <= ST_IDLE;
                    clr_busy <= 1'b0;
                end
            endcase
        end
    end

    // The clear owns the write port; user writes arriving while busy are dropped.
    always_ff @(posedge AClkH) begin
        if (AClkHEn) begin
            if (clr_busy)
                mem[clr_cnt] <= CFill;
            else if (f_wr_en)
                mem[f_addr_wr] <= wr_word;
        end
    end

    assign rd_raw = mem[f_addr_rd];

`ifdef RAM_XAXD_BYPASS_EN
    assign rd_hit = f_wr_en && (f_addr_wr == f_addr_rd) && !clr_busy;
`else
    assign rd_hit = 1'b0;
`endif

    for (genvar i = 0; i < CLaneCnt; i++) begin : g_lane
        ram_xaxd_be_clr_lane #(.CLaneLen(CLaneLen)) u_wr (
            .old_lane (mem[f_addr_wr][i]),
            .new_lane (f_mosi[i]),
            .sel      (f_wr_mask[i]),
            .lane     (wr_word[i])
        );
        ram_xaxd_be_clr_lane #(.CLaneLen(CLaneLen)) u_rd (
            .old_lane (rd_raw[i]),
            .new_lane (f_mosi[i]),
            .sel      (f_wr_mask[i] & rd_hit),
            .lane     (rd_word[i])
        );
    end

    assign rd_live = f_live ? rd_word : '0;

    if (CRdReg != 0) begin : g_oreg
        word_t rd_q;
        logic  vld_q;
        always_ff @(posedge AClkH or posedge AResetH) begin
            if (AResetH) begin
                rd_q  <= '0;
                vld_q <= 1'b0;
            end else if (AClkHEn) begin
                rd_q  <= rd_live;
                vld_q <= f_rd_en;
            end
        end
        assign bus.AMiso    = rd_q;
        assign bus.AMisoVld = vld_q;
    end else begin : g_comb
        assign bus.AMiso    = rd_live;
        assign bus.AMisoVld = f_rd_en;
    end

    assign bus.AClrBusy = clr_busy;
endmodule

// File: tb/tb_ram_xaxd_be_clr.sv
// Two 16-word instances (A: comb read, clear on reset; B: registered read, no clear on reset) driven
// by the same stimulus and checked every cycle against a word-level model of the RAM.
module tb_ram_xaxd_be_clr;
    logic        clk, rst, en, wen, ren, clr;
    logic [3:0]  waddr, raddr;
    logic [15:0] wdata;
    logic [1:0]  wmask;
    int          checks = 0, errors = 0, n, k;

    ram_xaxd_be_clr_if #(.CAddrLen(4)) ifa ();
    ram_xaxd_be_clr_if #(.CAddrLen(4)) ifb ();

    assign ifa.AAddrWr = waddr;  assign ifb.AAddrWr = waddr;
    assign ifa.AMosi   = wdata;  assign ifb.AMosi   = wdata;
    assign ifa.AWrEn   = wen;    assign ifb.AWrEn   = wen;
    assign ifa.AWrMask = wmask;  assign ifb.AWrMask = wmask;
    assign ifa.AAddrRd = raddr;  assign ifb.AAddrRd = raddr;
    assign ifa.ARdEn   = ren;    assign ifb.ARdEn   = ren;
    assign ifa.AClrReq = clr;    assign ifb.AClrReq = clr;

    ram_xaxd_be_clr #(.CAddrLen(4), .CRdReg(0), .CClrOnRst(1)) dut_a (
        .AClkH(clk), .AResetH(rst), .AClkHEn(en), .bus(ifa));
    ram_xaxd_be_clr #(.CAddrLen(4), .CRdReg(1), .CClrOnRst(0)) dut_b (
        .AClkH(clk), .AResetH(rst), .AClkHEn(en), .bus(ifb));

    always #5 clk = ~clk;

    // Model: index 0 is A, index 1 is B (the one with the output register).
    logic [15:0] mm [2][16];
    bit          mbusy [2];
    int          mcnt [2];
    logic [15:0] exp_d [2];
    bit          exp_v [2];
    bit          fwen, fren, fclr;
    logic [3:0]  fwa, fra;
    logic [15:0] fd;
    logic [1:0]  fm;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h at %0t", nm, got, exp, $time);
        end
    endtask

    function automatic logic [15:0] merge(logic [15:0] w, logic [15:0] d, logic [1:0] m);
        for (int i = 0; i < 2; i++) if (m[i]) w[i*8 +: 8] = d[i*8 +: 8];
        return w;
    endfunction

    function automatic logic [15:0] view(int d, logic [3:0] a);
        logic [15:0] w = mm[d][a];
`ifdef RAM_XAXD_BYPASS_EN
        if (fwen && fwa == a && !mbusy[d]) w = merge(w, fd, fm);
`endif
        return w;
    endfunction

    task automatic model_reset();
        fwen = 0; fren = 0; fclr = 0; fwa = 0; fra = 0; fd = 0; fm = 0;
        for (int d = 0; d < 2; d++) begin
            mbusy[d] = (d == 0);
            mcnt[d]  = 0;
            exp_d[d] = 0;
            exp_v[d] = 0;
        end
    endtask

    task automatic model_step();
        logic [15:0] rv [2];
        for (int d = 0; d < 2; d++) rv[d] = view(d, fra);
        for (int d = 0; d < 2; d++) begin
            if (d == 1) begin exp_d[d] = rv[d]; exp_v[d] = fren; end
            if (mbusy[d]) begin
                mm[d][mcnt[d]] = 16'h0000;
                if (mcnt[d] == 15) begin mbusy[d] = 0; mcnt[d] = 0; end
                else mcnt[d]++;
            end else begin
                if (fwen) mm[d][fwa] = merge(mm[d][fwa], fd, fm);
                if (fclr) begin mbusy[d] = 1; mcnt[d] = 0; end
            end
        end
        fwen = wen; fren = ren; fclr = clr; fwa = waddr; fra = raddr; fd = wdata; fm = wmask;
        exp_d[0] = view(0, fra);
        exp_v[0] = fren;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        if (!rst && en) model_step();
    endtask

    task automatic wr(input logic [3:0] a, input logic [15:0] d, input logic [1:0] m);
        waddr = a; wdata = d; wmask = m; wen = 1;
        tick();
        wen = 0;
    endtask

    always @(negedge clk) begin
        chk("a_busy", ifa.AClrBusy, mbusy[0]);
        chk("b_busy", ifb.AClrBusy, mbusy[1]);
        chk("a_vld", ifa.AMisoVld, exp_v[0]);
        chk("b_vld", ifb.AMisoVld, exp_v[1]);
        if (exp_v[0] && !$isunknown(exp_d[0])) chk("a_miso", ifa.AMiso, exp_d[0]);
        if (exp_v[1] && !$isunknown(exp_d[1])) chk("b_miso", ifb.AMiso, exp_d[1]);
    end

    initial begin
        for (int d = 0; d < 2; d++) for (int a = 0; a < 16; a++) mm[d][a] = 'x;
        clk = 0; rst = 1; en = 1; wen = 0; ren = 0; clr = 0;
        waddr = 0; raddr = 0; wdata = 0; wmask = 0;
        model_reset();
        #3;
        chk("rst_a_busy", ifa.AClrBusy, 1);
        chk("rst_b_busy", ifb.AClrBusy, 0);
        chk("rst_a_miso", ifa.AMiso, 0);
        chk("rst_b_miso", ifb.AMiso, 0);
        chk("rst_b_vld", ifb.AMisoVld, 0);
        tick(); tick();
        rst = 0;

        // A clears out of reset; the request makes B clear as well (A ignores it while busy).
        clr = 1; n = 0;
        while (ifa.AClrBusy && n < 40) begin tick(); clr = 0; n++; end
        chk("a_clr_len", n, 16);
        n = 0;
        while (ifb.AClrBusy && n < 40) begin tick(); n++; end
        chk("b_clr_done", ifb.AClrBusy, 0);
        for (int a = 0; a < 16; a++) begin raddr = 4'(a); ren = 1; tick(); end
        chk("a_rd15_clear", ifa.AMiso, 16'h0000);
        ren = 0; tick(); tick();

        // Lane masks, and B's two-edge read latency.
        wr(3, 16'hA55A, 2'b11);
        wr(3, 16'h12FF, 2'b01);
        tick();
        raddr = 3; ren = 1; tick(); ren = 0;
        chk("a_mask_merge", ifa.AMiso, 16'hA5FF);
        chk("b_vld_1edge", ifb.AMisoVld, 0);
        tick();
        chk("b_vld_2edge", ifb.AMisoVld, 1);
        chk("b_miso_2edge", ifb.AMiso, 16'hA5FF);
        tick();
        chk("b_vld_after", ifb.AMisoVld, 0);

        // Same-edge read/write collision.
        wr(7, 16'h1234, 2'b11);
        tick();
        waddr = 7; wdata = 16'hBEEF; wmask = 2'b10; wen = 1; raddr = 7; ren = 1;
        tick();
        wen = 0;
`ifdef RAM_XAXD_BYPASS_EN
        chk("a_collide", ifa.AMiso, 16'hBE34);
`else
        chk("a_collide", ifa.AMiso, 16'h1234);
`endif
        tick();
        chk("a_collide_next", ifa.AMiso, 16'hBE34);
        ren = 0;

        for (int i = 0; i < 400; i++) begin
            en = ($urandom_range(0, 7) != 0);
            wen = 1'($urandom); ren = 1'($urandom);
            waddr = 4'($urandom); raddr = 4'($urandom);
            wdata = 16'($urandom); wmask = 2'($urandom);
            clr = ($urandom_range(0, 49) == 0);
            tick();
        end
        en = 1; wen = 0; ren = 0; clr = 0; n = 0;
        while ((ifa.AClrBusy || ifb.AClrBusy) && n < 100) begin tick(); n++; end
        chk("idle_wait", {ifa.AClrBusy, ifb.AClrBusy}, 0);

        // Clear with a gated clock; a write issued mid-clear is dropped.
        clr = 1; tick(); clr = 0; tick();
        chk("tog_busy_start", ifb.AClrBusy, 1);
        n = 0; k = 0;
        while (ifb.AClrBusy && k < 100) begin
            en = (k % 2 == 0);
            wen = (k == 6); waddr = 1; wdata = 16'hFFFF; wmask = 2'b11;
            tick();
            if (en) n++;
            k++;
        end
        en = 1; wen = 0;
        chk("tog_clr_len", n, 16);
        raddr = 1; ren = 1; tick(); ren = 0;
        chk("clr_drops_wr", ifa.AMiso, 16'h0000);
        tick(); tick();

        // Reset at clear count 5: B stops with a partially cleared array.
        for (int a = 0; a < 16; a++) wr(4'(a), 16'h5A00 | 16'(a), 2'b11);
        tick();
        clr = 1; tick(); clr = 0; tick();
        repeat (5) tick();
        rst = 1;
        model_reset();
        #1;
        chk("b_busy_rst", ifb.AClrBusy, 0);
        chk("a_busy_rst", ifa.AClrBusy, 1);
        chk("b_miso_rst", ifb.AMiso, 0);
        tick();
        rst = 0;
        raddr = 4; ren = 1; tick();
        raddr = 5; tick();
        chk("b_partial_4", ifb.AMiso, 16'h0000);
        ren = 0; tick();
        chk("b_partial_5", ifb.AMiso, 16'h5A05);
        for (int a = 0; a < 16; a++) begin raddr = 4'(a); ren = 1; tick(); end
        ren = 0; tick(); tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/ram_xaxd_be_clr.md
Name: ram_xaxd_be_clr

Overview:
- Parametrised single-clock simulation RAM with independent registered write and read ports, AClkHEn-gated like the rest of the Mem/Sim family.
- Extends the plain XaXd RAM with per-lane byte write masks and an optional output register with a read-valid strobe.
- Adds a sequential clear engine, so reset no longer zeroes the whole array in one step.
- Used as a drop-in peripheral/scope buffer model where mask writes and bulk clear are needed.

Parameters:
CAddrLen, 8, address width; depth CRamSize = 1<<CAddrLen
CLaneLen, 8, bits per write lane
CLaneCnt, 2, number of lanes; data width CDataLen = CLaneLen*CLaneCnt
CRdReg, 0, 0 = read data one edge after address sample; 1 = one extra output register
CClrOnRst, 1, 1 = clear engine starts automatically after reset
CClrVal, 0, fill value per lane, replicated across all lanes during clear

Ports:
AClkH  in  1  clock, rising edge
AResetH  in  1  asynchronous reset, active high
AClkHEn  in  1  clock enable; all state advances only when 1
AAddrWr  in  CAddrLen  write address
AMosi  in  CDataLen  write data
AWrEn  in  1  write request
AWrMask  in  CLaneCnt  lane enables; bit i covers bits [i*CLaneLen +: CLaneLen]
AAddrRd  in  CAddrLen  read address
ARdEn  in  1  read request (drives AMisoVld only; array is always readable)
AMiso  out  CDataLen  read data
AMisoVld  out  1  AMiso valid for a request
AClrReq  in  1  start bulk clear (level sampled)
AClrBusy  out  1  clear in progress

Behaviour:
- Reset (AResetH=1, async): input/pipe regs are 0, AMiso=0, AMisoVld=0.
  - AClrBusy=CClrOnRst, clear counter=0.
  - Array contents are not touched by reset.
- Edge E0 (AClkHEn=1) registers AAddrWr, AMosi, AWrEn, AWrMask, AAddrRd, ARdEn into F* regs.
- Write commit at edge E1 (AClkHEn=1):
  - If FWrEn and not busy: mem[FAddrWr] lanes with FWrMask=1 take FMosi; other lanes are unchanged.
  - FWrEn with FWrMask=0 is a no-op.
- Read, CRdReg=0: AMiso = mem[FAddrRd] combinationally after E0; AMisoVld = FRdEn.
- Read, CRdReg=1: AMiso and AMisoVld are registered at E1 from the CRdReg=0 values; latency is 2 edges.
- Read/write collision, same address sampled at the same E0: see Optional Feature. Write to a different address never affects AMiso.
- AClkHEn=0: all regs and the array hold; AMiso holds.
- Clear engine, states IDLE and CLR:
  - IDLE -> CLR when FClrReq=1 at an enabled edge, or out of reset with CClrOnRst=1. The counter loads 0.
  - In CLR, each enabled edge writes the full word {CLaneCnt{CClrVal}} to mem[cnt], then cnt++.
  - User writes are dropped (not queued) while in CLR.
  - Reads stay functional; they return the cleared or old value depending on cnt.
  - On the write to cnt = CRamSize-1: cnt wraps to 0 and the next state is IDLE.
- AClrBusy = (state==CLR), registered. A clear takes exactly CRamSize enabled edges.
- AClrReq while in CLR is ignored; a clear is never restarted.
- Reset mid-clear aborts the clear.
  - If CClrOnRst=1 the clear restarts from 0; otherwise it returns to IDLE with a partially cleared array.

Optional Feature:
- Macro RAM_XAXD_BYPASS_EN.
- Defined: write-first forwarding. If FWrEn and FAddrWr==FAddrRd and not busy, the masked lanes of AMiso come from FMosi and the unmasked lanes from the array. AMiso is therefore the post-write value in the same cycle.
- Undefined: read-first. AMiso shows the pre-write array value until the next read of that address.
- With CRdReg=1, the registered stage captures whichever value the selected mode produced.

Test Plan:
- Reset, CClrOnRst=1, CAddrLen=4: AClrBusy=1 for exactly 16 enabled edges, then 0. Reading every address returns 0x0000.
- Write 0xA55A to addr 3 with mask 2'b11, then 0x12FF with mask 2'b01 -> read of addr 3 returns 0xA5FF.
- Same-edge write 0xBEEF (mask 2'b10) and read of addr 7 holding 0x1234:
  - macro defined -> AMiso = 0xBE34;
  - macro undefined -> AMiso = 0x1234, and the next read = 0xBE34.
- CRdReg=1: read addr 3 requested with ARdEn=1 -> AMisoVld and data arrive 2 edges after the request.
- AClkHEn toggled 1/0 during a clear: busy length counts enabled edges only (16). A write issued during busy leaves its target at CClrVal.
- AResetH asserted at clear count 5 with CClrOnRst=0: AClrBusy=0 immediately. Addr 0..4 = CClrVal; addr 5..15 keep their prior contents.
